// File: rtl/v_state_sched.sv
// State scheduler: arbitrates two read pipes and a buffered write stream onto one
// single-port state RAM, forwarding buffered writes to reads so ordering is preserved.

package v_pkg;
  typedef logic [7:0]  addr_t;
  typedef logic [15:0] state_t;
endpackage

module v_state_sched #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_wr_en,
  input  v_pkg::addr_t                    i_wr_addr,
  input  v_pkg::state_t                   i_wr_data,
  input  logic                            i_upd_ren,
  input  v_pkg::addr_t                    i_upd_raddr,
  output logic                            o_upd_rgnt,
  output logic                            o_upd_rvld_r,
  output v_pkg::state_t                   o_upd_rdata_r,
  input  logic                            i_qry_ren,
  input  v_pkg::addr_t                    i_qry_raddr,
  output logic                            o_qry_rgnt,
  output logic                            o_qry_rvld_r,
  output v_pkg::state_t                   o_qry_rdata_r,
  output logic                            o_ram_en,
  output logic                            o_ram_wen,
  output v_pkg::addr_t                    o_ram_addr,
  output v_pkg::state_t                   o_ram_wdata,
  input  v_pkg::state_t                   i_ram_rdata,
  output logic [$clog2(WBUF_DEPTH+1)-1:0] o_wbuf_cnt_r
);
  import v_pkg::*;

  localparam int CW = $clog2(WBUF_DEPTH + 1);
  localparam int PW = $clog2(WBUF_DEPTH);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_qry_q, rr_qry_d;
  logic          upd_rvld_q, upd_rvld_d;
  logic          qry_rvld_q, qry_rvld_d;
  logic          fwd_hit_q, fwd_hit_d;
  state_t        fwd_data_q, fwd_data_d;
  addr_t         wbuf_addr_q [WBUF_DEPTH];
  state_t        wbuf_data_q [WBUF_DEPTH];

  logic          forced, rd_allow, gnt_upd, gnt_qry, drain, push;
  addr_t         rd_addr;
  logic [PW-1:0] scan_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Nothing is granted or pushed while reset is held, so the RAM stays idle then.
  always_comb begin
    forced   = rst_n && (cnt_q >= CW'(WBUF_DEPTH - 1));
    rd_allow = rst_n && !forced;
    gnt_upd  = rd_allow && i_upd_ren && (!i_qry_ren || !rr_qry_q);
    gnt_qry  = rd_allow && i_qry_ren && (!i_upd_ren || rr_qry_q);
    drain    = forced || (rd_allow && !i_upd_ren && !i_qry_ren && (cnt_q != '0));
    push     = rst_n && i_wr_en;
    rd_addr  = gnt_qry ? i_qry_raddr : i_upd_raddr;
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    rr_qry_d   = rr_qry_q;
    upd_rvld_d = gnt_upd;
    qry_rvld_d = gnt_qry;
    if (push)  tail_d = ptr_inc(tail_q);
    if (drain) head_d = ptr_inc(head_q);
    case ({push, drain})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (gnt_upd)      rr_qry_d = 1'b1;
    else if (gnt_qry) rr_qry_d = 1'b0;
  end

  // Scan oldest to newest so the last hit (then the same-cycle write) wins.
  always_comb begin
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
    scan_idx   = head_q;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((CW'(i) < cnt_q) && (wbuf_addr_q[scan_idx] == rd_addr)) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = wbuf_data_q[scan_idx];
      end
      scan_idx = ptr_inc(scan_idx);
    end
    if (push && (i_wr_addr == rd_addr)) begin
      fwd_hit_d  = 1'b1;
      fwd_data_d = i_wr_data;
    end
    if (!(gnt_upd || gnt_qry)) fwd_hit_d = 1'b0;
  end

  always_comb begin
    o_ram_en    = gnt_upd || gnt_qry || drain;
    o_ram_wen   = drain;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (drain) begin
      o_ram_addr  = wbuf_addr_q[head_q];
      o_ram_wdata = wbuf_data_q[head_q];
    end else if (gnt_upd || gnt_qry) begin
      o_ram_addr  = rd_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      rr_qry_q   <= 1'b0;
      upd_rvld_q <= 1'b0;
      qry_rvld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      rr_qry_q   <= rr_qry_d;
      upd_rvld_q <= upd_rvld_d;
      qry_rvld_q <= qry_rvld_d;
    end
  end

  // NOTE: buffer storage and forward data are not reset; occupancy and valid flags qualify them.
  always_ff @(posedge clk) begin
    if (push) begin
      wbuf_addr_q[tail_q] <= i_wr_addr;
      wbuf_data_q[tail_q] <= i_wr_data;
    end
    fwd_hit_q  <= fwd_hit_d;
    fwd_data_q <= fwd_data_d;
  end

  assign o_upd_rgnt    = gnt_upd;
  assign o_qry_rgnt    = gnt_qry;
  assign o_upd_rvld_r  = upd_rvld_q;
  assign o_qry_rvld_r  = qry_rvld_q;
  assign o_upd_rdata_r = fwd_hit_q ? fwd_data_q : i_ram_rdata;
  assign o_qry_rdata_r = fwd_hit_q ? fwd_data_q : i_ram_rdata;
  assign o_wbuf_cnt_r  = cnt_q;

  // Forced drain at DEPTH-1 guarantees a free slot for the unconditional push.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) cnt_q < CW'(WBUF_DEPTH));

endmodule

// File: doc/v_state_sched.md
V_STATE_SCHED -- requirements
Module: v_state_sched

Interface
REQ-001 Parameter WBUF_DEPTH, default 4, legal range 2..16: write-buffer entries.
REQ-002 clk  in  1  sole clock; all flops rise on posedge clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 i_wr_en  in  1  update-pipe state write; accepted unconditionally, no back-pressure.
REQ-005 i_wr_addr / i_wr_data  in  v_pkg::addr_t / v_pkg::state_t  write address/data.
REQ-006 i_upd_ren  in  1  update-pipe read request; held until granted.
REQ-007 i_upd_raddr  in  v_pkg::addr_t  update-pipe read address.
REQ-008 o_upd_rgnt  out  1  update read accepted this cycle (combinational).
REQ-009 o_upd_rvld_r / o_upd_rdata_r  out  1 / v_pkg::state_t  update read response.
REQ-010 i_qry_ren, i_qry_raddr, o_qry_rgnt, o_qry_rvld_r, o_qry_rdata_r: query-pipe equivalents of REQ-006..009.
REQ-011 o_ram_en / o_ram_wen  out  1 / 1  single-port state RAM enable/write-enable.
REQ-012 o_ram_addr / o_ram_wdata  out  v_pkg::addr_t / v_pkg::state_t  RAM address/write data.
REQ-013 i_ram_rdata  in  v_pkg::state_t  RAM read data, valid one cycle after read enable.
REQ-014 o_wbuf_cnt_r  out  $clog2(WBUF_DEPTH+1)  current write-buffer occupancy.

Function
REQ-015 Block SHALL perform at most one RAM access per cycle (read XOR write).
REQ-016 Each i_wr_en SHALL push {addr,data} into an in-order write FIFO; RAM writes come only from FIFO head.
REQ-017 Forced drain: when registered count >= WBUF_DEPTH-1, cycle SHALL be a RAM write of FIFO head; no read grant.
REQ-018 Otherwise, if any read request, one read SHALL be granted; else, if FIFO non-empty, head SHALL drain; else o_ram_en=0.
REQ-019 Push and pop in same cycle SHALL leave count unchanged; count SHALL never reach WBUF_DEPTH (assertion).
REQ-020 Read arbitration SHALL be round-robin: one-bit pointer (reset: upd preferred) moves to the other requester after each grant; sole requester always wins when reads are allowed.
REQ-021 Grant SHALL drive o_ram_en=1, o_ram_wen=0, o_ram_addr=granted raddr; granted requester's rvld_r SHALL be 1 next cycle, with rdata_r returned that cycle.
REQ-022 Ordering: a write whose i_wr_en is in cycle t or earlier SHALL be visible to any read granted in cycle t or later.
REQ-023 Forwarding: at grant, newest matching entry among FIFO contents plus same-cycle incoming write SHALL be captured; response SHALL return that data instead of i_ram_rdata.
REQ-024 No match: response SHALL return i_ram_rdata.
REQ-025 Entry drained in the grant cycle is not a read-grant case (single port); entry popped in the same cycle as a later match SHALL still be forwarded if matched at grant.
REQ-026 rvld_r SHALL be a single-cycle pulse per grant; back-to-back grants SHALL give back-to-back responses.
REQ-027 Ungranted request SHALL keep ren/raddr stable; block SHALL not store requests.

Reset
REQ-028 On rst_n low, immediately: FIFO empty, o_wbuf_cnt_r=0, rvld_r outputs 0, RR pointer=upd, o_ram_en=0, o_ram_wen=0.
REQ-029 Writes and grants during reset SHALL be ignored; in-flight responses and buffered writes SHALL be discarded.
REQ-030 rdata_r outputs are unreset; meaningful only with rvld_r.

Verification
REQ-031 Reads only, both requesting every cycle for 6 cycles -> grants alternate upd,qry,upd,...; rvld pulses one cycle after each grant.
REQ-032 Write addr 5 data 0xA at t, upd read addr 5 granted at t -> o_upd_rdata_r=0xA at t+1 (forwarded), RAM data ignored.
REQ-033 Writes to 5 (0x1) then 5 (0x2) buffered, read 5 -> returns 0x2 (newest match).
REQ-034 WBUF_DEPTH=4, write every cycle with continuous reads -> count saturates at 3, forced drains every cycle, no grants while forced, no overflow.
REQ-035 Idle requesters, 3 buffered writes -> drained in order over 3 cycles, count 3->0, RAM sees addresses in push order.
REQ-036 Assert rst_n low mid-stream with 2 buffered writes and a pending response -> count=0, rvld_r=0 immediately; no RAM write after release until new i_wr_en.
